// File: rtl/ysyx_24080014_pc_seq.sv
// PC owner and instruction sequencer for the single-issue core.
// Steps each instruction through request, response wait, execute and commit.
module ysyx_24080014_pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [31:0]      ifu_req_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_data,
  input  logic             ifu_rsp_err,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  input  logic             exu_done,
  input  logic [31:0]      exu_next_pc,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_EXEC = 3'd3,
    S_HALT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic             inst_valid_q, inst_valid_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             next_pc_misaligned;
  assign next_pc_misaligned = (exu_next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
      retired_q    <= retired_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    fault_d      = fault_q;
    retired_d    = retired_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (ifu_req_ready) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            inst_d       = ifu_rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        if (exu_done) begin
          inst_valid_d = 1'b0;
          // A misaligned target is not committed: pc and retired keep the faulting context.
          if (next_pc_misaligned) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d      = exu_next_pc;
            retired_d = retired_q + CNT_W'(1);
            state_d   = halt_req ? S_HALT : S_REQ;
          end
        end
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase
  end

  // Request valid is decoded from state so an async reset drops it at once.
  assign ifu_req_valid = (state_q == S_REQ);
  assign ifu_req_addr  = pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign pc            = pc_q;
  assign halted        = (state_q == S_HALT);
  assign fault         = fault_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_ysyx_24080014_pc_seq.sv
// Self-checking bench for ysyx_24080014_pc_seq: directed table, corner sequences,
// and randomized instruction streams checked against a transaction-level model.
module tb_ysyx_24080014_pc_seq;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CNT_W    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ifu_req_valid;
  logic             ifu_req_ready;
  logic [31:0]      ifu_req_addr;
  logic             ifu_rsp_valid;
  logic [31:0]      ifu_rsp_data;
  logic             ifu_rsp_err;
  logic             inst_valid;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic             exu_done;
  logic [31:0]      exu_next_pc;
  logic             halt_req;
  logic [31:0]      pc;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;

  ysyx_24080014_pc_seq #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .exu_done(exu_done), .exu_next_pc(exu_next_pc), .halt_req(halt_req),
    .pc(pc), .halted(halted), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Architectural model: what the core should look like between transactions.
  logic [31:0] m_pc;
  int          m_retired;
  logic        m_fault;
  logic        m_halted;

  typedef struct {
    int          rdy_dly;
    int          rsp_dly;
    int          exe_dly;
    logic [31:0] data;
    logic [31:0] npc;
    logic [31:0] exp_pc;
    int          exp_ret;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = '0;
    ifu_rsp_err   = 1'b0;
    exu_done      = 1'b0;
    exu_next_pc   = '0;
    halt_req      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_async_req_valid", ifu_req_valid, 0);
    tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_req_valid", ifu_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_retired", retired, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_req_valid", ifu_req_valid, 1);
    check("post_rst_req_addr", ifu_req_addr, RESET_PC);
    m_pc      = RESET_PC;
    m_retired = 0;
    m_fault   = 1'b0;
    m_halted  = 1'b0;
    $display("reset: pc=0x%08h", pc);
  endtask

  // One instruction from request to commit; strays exercise the ignore rules.
  task automatic do_instr(input int rdy_dly, input int rsp_dly, input int exe_dly,
                          input logic [31:0] data, input logic err,
                          input logic [31:0] npc, input logic hlt, input bit stray);
    logic [31:0] fetch_pc;
    fetch_pc = m_pc;
    check("req_valid", ifu_req_valid, 1);
    check("req_addr", ifu_req_addr, fetch_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      if (stray) begin
        ifu_rsp_valid = 1'($urandom_range(0, 1));
        ifu_rsp_data  = $urandom();
        exu_done      = 1'($urandom_range(0, 1));
        exu_next_pc   = $urandom();
        halt_req      = 1'($urandom_range(0, 1));
      end
      tick();
      clear_inputs();
      check("bp_req_valid", ifu_req_valid, 1);
      check("bp_req_addr", ifu_req_addr, fetch_pc);
    end
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    check("wait_req_valid", ifu_req_valid, 0);
    for (int i = 0; i < rsp_dly; i++) begin
      if (stray) begin
        exu_done    = 1'($urandom_range(0, 1));
        exu_next_pc = $urandom();
        halt_req    = 1'($urandom_range(0, 1));
      end
      tick();
      clear_inputs();
      check("wait_inst_valid", inst_valid, 0);
      check("wait_pc", pc, fetch_pc);
    end
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = data;
    ifu_rsp_err   = err;
    tick();
    clear_inputs();
    if (err) begin
      m_fault  = 1'b1;
      m_halted = 1'b1;
      check("err_fault", fault, 1);
      check("err_halted", halted, 1);
      check("err_inst_valid", inst_valid, 0);
      $display("instr pc=0x%08h fetch error -> halt", fetch_pc);
      return;
    end
    check("exec_inst_valid", inst_valid, 1);
    check("exec_inst", inst, data);
    check("exec_inst_pc", inst_pc, fetch_pc);
    for (int i = 0; i < exe_dly; i++) begin
      if (stray) begin
        ifu_rsp_valid = 1'($urandom_range(0, 1));
        ifu_rsp_data  = $urandom();
        halt_req      = 1'($urandom_range(0, 1));
      end
      tick();
      clear_inputs();
      check("exec_hold_valid", inst_valid, 1);
      check("exec_hold_inst", inst, data);
    end
    exu_done    = 1'b1;
    exu_next_pc = npc;
    halt_req    = hlt;
    tick();
    clear_inputs();
    if (npc[1:0] != 2'b00) begin
      m_fault  = 1'b1;
      m_halted = 1'b1;
    end else begin
      m_pc      = npc;
      m_retired = (m_retired + 1) % (1 << CNT_W);
      if (hlt) m_halted = 1'b1;
    end
    check("commit_pc", pc, m_pc);
    check("commit_retired", retired, m_retired);
    check("commit_fault", fault, m_fault);
    check("commit_halted", halted, m_halted);
    check("commit_inst_valid", inst_valid, 0);
    check("commit_req_valid", ifu_req_valid, !m_halted);
    $display("instr pc=0x%08h inst=0x%08h next=0x%08h halt=%0d -> pc=0x%08h retired=%0d",
             fetch_pc, data, npc, hlt, pc, retired);
  endtask

  // Halted core must ignore everything and keep its outputs still.
  task automatic check_frozen(input int n);
    for (int i = 0; i < n; i++) begin
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'($urandom_range(0, 1));
      ifu_rsp_data  = $urandom();
      exu_done      = 1'($urandom_range(0, 1));
      exu_next_pc   = $urandom() & 32'hFFFF_FFFC;
      halt_req      = 1'($urandom_range(0, 1));
      tick();
      clear_inputs();
      check("halt_req_valid", ifu_req_valid, 0);
      check("halt_halted", halted, 1);
      check("halt_pc", pc, m_pc);
      check("halt_retired", retired, m_retired);
      check("halt_fault", fault, m_fault);
    end
  endtask

  vec_t vecs[5];

  initial begin
    time t0;
    logic [31:0] pc_before;
    int          ret_before;

    clear_inputs();
    rst_n = 1'b1;
    #2;

    vecs[0] = '{3, 0, 1, 32'h0000_0013, 32'h8000_0004, 32'h8000_0004, 1};
    vecs[1] = '{0, 2, 0, 32'h0010_0093, 32'h8000_0100, 32'h8000_0100, 2};
    vecs[2] = '{1, 1, 2, 32'h0000_0297, 32'h8000_0104, 32'h8000_0104, 3};
    vecs[3] = '{0, 0, 0, 32'h0000_006f, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4};
    vecs[4] = '{2, 0, 0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 5};

    // Reset, back-pressure, jumps (next fetch address checked at the start of each entry).
    do_reset();
    foreach (vecs[i]) begin
      do_instr(vecs[i].rdy_dly, vecs[i].rsp_dly, vecs[i].exe_dly, vecs[i].data, 1'b0,
               vecs[i].npc, 1'b0, 1'b0);
      check("vec_pc", pc, vecs[i].exp_pc);
      check("vec_retired", retired, vecs[i].exp_ret);
    end
    check("jump_fetch_addr", ifu_req_addr, 32'h0000_0000);

    // Ten sequential instructions, zero-wait memory, EXU answering one cycle after inst_valid.
    do_reset();
    t0 = $time;
    for (int i = 0; i < 10; i++) do_instr(0, 0, 1, 32'h0000_0013, 1'b0, m_pc + 32'd4, 1'b0, 1'b0);
    check("seq_cycles", ($time - t0) / 10, 40);
    check("seq_retired", retired, 10);
    check("seq_pc", pc, 32'h8000_0028);

    // Misaligned next PC: no commit, fault, halt.
    pc_before  = m_pc;
    ret_before = m_retired;
    do_instr(0, 0, 0, 32'h0000_0067, 1'b0, 32'h8000_0102, 1'b0, 1'b0);
    check("misalign_pc", pc, pc_before);
    check("misalign_retired", retired, ret_before);
    check("misalign_fault", fault, 1);
    check_frozen(4);

    // ebreak retires then halts.
    do_reset();
    do_instr(0, 0, 0, 32'h0010_0073, 1'b0, 32'h8000_0004, 1'b1, 1'b0);
    check("ebreak_retired", retired, 1);
    check("ebreak_halted", halted, 1);
    check("ebreak_fault", fault, 0);
    check_frozen(4);

    // Fetch access fault.
    do_reset();
    do_instr(1, 1, 0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0);
    check_frozen(4);
    check("err_inst_valid_hold", inst_valid, 0);

    // Reset asserted while a request is pending.
    do_reset();
    check("midreq_valid_before", ifu_req_valid, 1);
    do_reset();

    // Random streams against the model; retired wraps within long segments.
    for (int seg = 0; seg < 8; seg++) begin
      int n;
      do_reset();
      n = $urandom_range(20, 60);
      for (int k = 0; k < n && !m_halted; k++) begin
        int          sel;
        logic [31:0] npc;
        logic        err;
        logic        hlt;
        sel = $urandom_range(0, 99);
        if (sel < 70)      npc = m_pc + 32'd4;
        else if (sel < 95) npc = $urandom() & 32'hFFFF_FFFC;
        else               npc = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        err = ($urandom_range(0, 49) == 0);
        hlt = ($urandom_range(0, 39) == 0);
        do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom(), err, npc, hlt, 1'b1);
      end
      if (m_halted) check_frozen(3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
